// File: rtl/tatzel_trim_sar.sv
// ----------------------------------------------------------------------------
// tatzel_trim_sar
//   Successive-approximation trim calibrator. Walks the trim code from MSB to
//   LSB. For each trial bit it waits for the analog reference to settle, then
//   samples the synchronized comparator and keeps or clears that bit. The final
//   code is the largest code for which the comparator reads 0.
//
//   Optional feature macro: TATZEL_TRIM_AVG_EN
//     defined   -> SAMPLE spans 3 cycles and uses a 2-of-3 majority vote of cmp_s
//     undefined -> SAMPLE is a single cycle that uses cmp_s directly
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : one-cycle calibration request (ignored while busy or in DONE)
//   abort      : cancels a running calibration; wins over start
//   cmp_in     : asynchronous comparator, 1 = reference above target
//   trim_code  : trim code driven to the reference
//   busy       : high in SETTLE and SAMPLE
//   done       : one-cycle completion pulse
//   cal_valid  : trim_code holds a completed calibration result
// ----------------------------------------------------------------------------
module tatzel_trim_sar #(
    parameter int TRIM_W        = 6,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim_code,
    output logic              busy,
    output logic              done,
    output logic              cal_valid
);

    localparam int                IDX_W       = $clog2(TRIM_W);
    localparam logic [IDX_W-1:0]  MSB_IDX     = IDX_W'(TRIM_W - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [TRIM_W-1:0] MID_CODE    = {1'b1, {(TRIM_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_cmp_meta, r_cmp_s;
    logic [TRIM_W-1:0]  r_trim, w_trim_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt, w_idx_dn;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic               r_cal_valid, w_cal_valid_nxt;
    logic               w_bit_clear;    // 1 = reference too high, drop the trial bit
    logic               w_sample_last;  // last SAMPLE cycle of the current bit
    logic               w_busy;

`ifdef TATZEL_TRIM_AVG_EN
    logic [1:0]         r_scnt, w_scnt_nxt;    // SAMPLE cycle index 0..2
    logic [1:0]         r_votes, w_votes_nxt;  // cmp_s from SAMPLE cycles 0 and 1
`endif

    assign w_idx_dn = r_idx - IDX_W'(1);
    assign w_busy   = (r_state == S_SETTLE) || (r_state == S_SAMPLE);

    // NOTE: every flop, synchronizer included, has an async reset so that the
    // outputs return to their idle values without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_meta  <= 1'b0;
            r_cmp_s     <= 1'b0;
            r_state     <= S_IDLE;
            r_trim      <= MID_CODE;
            r_idx       <= MSB_IDX;
            r_cnt       <= '0;
            r_cal_valid <= 1'b0;
`ifdef TATZEL_TRIM_AVG_EN
            r_scnt      <= '0;
            r_votes     <= '0;
`endif
        end else begin
            r_cmp_meta  <= cmp_in;
            r_cmp_s     <= r_cmp_meta;
            r_state     <= w_state_nxt;
            r_trim      <= w_trim_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cal_valid <= w_cal_valid_nxt;
`ifdef TATZEL_TRIM_AVG_EN
            r_scnt      <= w_scnt_nxt;
            r_votes     <= w_votes_nxt;
`endif
        end
    end

    // NOTE: every signal written here gets a hold/default value first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_trim_nxt      = r_trim;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_cal_valid_nxt = r_cal_valid;
`ifdef TATZEL_TRIM_AVG_EN
        w_scnt_nxt      = r_scnt;
        w_votes_nxt     = r_votes;
        w_sample_last   = (r_scnt == 2'd2);
        w_bit_clear     = (r_votes[0] & r_votes[1]) |
                          (r_votes[0] & r_cmp_s)    |
                          (r_votes[1] & r_cmp_s);
`else
        w_sample_last   = 1'b1;
        w_bit_clear     = r_cmp_s;
`endif

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt     = S_SETTLE;
                    w_trim_nxt      = MID_CODE;
                    w_idx_nxt       = MSB_IDX;
                    w_cnt_nxt       = '0;
                    w_cal_valid_nxt = 1'b0;
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            S_SAMPLE: begin
`ifdef TATZEL_TRIM_AVG_EN
                if (!w_sample_last) begin
                    w_votes_nxt[r_scnt[0]] = r_cmp_s;
                    w_scnt_nxt             = r_scnt + 2'd1;
                end else begin
                    w_scnt_nxt             = '0;
                end
`endif
                if (w_sample_last) begin
                    if (w_bit_clear) begin
                        w_trim_nxt[r_idx] = 1'b0;
                    end
                    if (r_idx != '0) begin
                        w_trim_nxt[w_idx_dn] = 1'b1;
                        w_idx_nxt            = w_idx_dn;
                        w_state_nxt          = S_SETTLE;
                    end else begin
                        // Result is final here, so cal_valid rises with done.
                        w_state_nxt     = S_DONE;
                        w_cal_valid_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides whatever the running state decided this cycle.
        if (abort && w_busy) begin
            w_state_nxt     = S_IDLE;
            w_trim_nxt      = MID_CODE;
            w_idx_nxt       = MSB_IDX;
            w_cnt_nxt       = '0;
            w_cal_valid_nxt = 1'b0;
`ifdef TATZEL_TRIM_AVG_EN
            w_scnt_nxt      = '0;
`endif
        end
    end

    assign trim_code = r_trim;
    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign cal_valid = r_cal_valid;

endmodule

// File: tb/tb_tatzel_trim_sar.sv
// ----------------------------------------------------------------------------
// tb_tatzel_trim_sar
//   Self-checking bench for tatzel_trim_sar (TRIM_W=6, SETTLE_CYCLES=16).
//   The comparator is modelled as cmp_in = (trim_code >= threshold), with an
//   optional one-cycle inversion (glitch). The expected result is the largest
//   code whose comparator reading is 0, found by scanning all codes.
//   Honours TATZEL_TRIM_AVG_EN for the expected busy length and glitch runs.
// ----------------------------------------------------------------------------
module tb_tatzel_trim_sar;

    localparam int TRIM_W        = 6;
    localparam int SETTLE_CYCLES = 16;
`ifdef TATZEL_TRIM_AVG_EN
    localparam int SAMPLE_LEN    = 3;
`else
    localparam int SAMPLE_LEN    = 1;
`endif
    localparam int PER_BIT       = SETTLE_CYCLES + SAMPLE_LEN;
    localparam int BUSY_EXP      = TRIM_W * PER_BIT;
    localparam int MID           = 1 << (TRIM_W - 1);
    localparam int CODE_MAX      = (1 << TRIM_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              cmp_in;
    logic [TRIM_W-1:0] trim_code;
    logic              busy;
    logic              done;
    logic              cal_valid;

    int   threshold;
    logic glitch;
    int   n_checks = 0;
    int   n_fail   = 0;

    tatzel_trim_sar #(
        .TRIM_W        (TRIM_W),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cmp_in    (cmp_in),
        .trim_code (trim_code),
        .busy      (busy),
        .done      (done),
        .cal_valid (cal_valid)
    );

    always #5 clk = ~clk;

    // Analog reference + comparator model.
    always_comb cmp_in = ((int'(trim_code) >= threshold) ? 1'b1 : 1'b0) ^ glitch;

    function automatic bit model_cmp(input int code, input int thr);
        return (code >= thr);
    endfunction

    // Largest code with comparator 0; saturates at 0 when none exists.
    function automatic int model_result(input int thr);
        int best = 0;
        for (int c = 0; c <= CODE_MAX; c++) begin
            if (!model_cmp(c, thr)) best = c;
        end
        return best;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Full calibration: start pulse, observe busy/done per cycle, check result.
    task automatic run_cal(input int thr, input bit do_glitch, input bit do_spam, input string tag);
        int busy_cnt, first_busy, last_busy, done_cnt, done_at, cv_busy;
        busy_cnt = 0; first_busy = -1; last_busy = -1;
        done_cnt = 0; done_at = -1; cv_busy = 0;
        threshold = thr;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < BUSY_EXP + 8; i++) begin
            start  = (do_spam && i < BUSY_EXP && (i % 7 == 3));
            glitch = (do_glitch && i < BUSY_EXP && (i % PER_BIT == SETTLE_CYCLES - 1));
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = i;
                last_busy = i;
                if (cal_valid) cv_busy++;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            @(posedge clk); #1;
        end
        start  = 1'b0;
        glitch = 1'b0;
        check({tag, "_busy_cycles"}, busy_cnt, BUSY_EXP);
        check({tag, "_first_busy"}, first_busy, 0);
        check({tag, "_last_busy"}, last_busy, BUSY_EXP - 1);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, BUSY_EXP);
        check({tag, "_cv_low_busy"}, cv_busy, 0);
        check({tag, "_trim"}, trim_code, model_result(thr));
        check({tag, "_cal_valid"}, cal_valid, 1);
    endtask

    initial begin
        int busy_seen, done_seen, thr;
        rst = 1'b1; start = 1'b0; abort = 1'b0; glitch = 1'b0; threshold = 37;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_trim", trim_code, MID);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cal_valid", cal_valid, 0);
        @(negedge clk); rst = 1'b0;

        // Threshold search, rails, start spam.
        run_cal(37, 1'b0, 1'b0, "thr37");
        run_cal(0,  1'b0, 1'b0, "rail_lo");
        run_cal(64, 1'b0, 1'b0, "rail_hi");
        run_cal(37, 1'b0, 1'b1, "spam");

        // Random thresholds, with and without start spam.
        for (int k = 0; k < 6; k++) begin
            thr = int'($urandom_range(0, 64));
            run_cal(thr, 1'b0, (k % 2 == 1), $sformatf("rnd%0d_t%0d", k, thr));
        end

`ifdef TATZEL_TRIM_AVG_EN
        // Single-cycle cmp glitch landing in the middle SAMPLE cycle of each bit.
        run_cal(37, 1'b1, 1'b0, "glitch37");
        for (int k = 0; k < 3; k++) begin
            thr = int'($urandom_range(0, 64));
            run_cal(thr, 1'b1, 1'b0, $sformatf("glitch_rnd%0d_t%0d", k, thr));
        end
`endif

        // Abort during the third SETTLE.
        threshold = 37;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2 * PER_BIT + 5) @(posedge clk);
        #1;
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_trim", trim_code, MID);
        check("abort_cal_valid", cal_valid, 0);
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < 3 * PER_BIT; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        check("abort_no_busy", busy_seen, 0);
        check("abort_no_done", done_seen, 0);

        // start and abort together from IDLE: nothing starts.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("start_abort_busy", busy_seen, 0);
        check("start_abort_trim", trim_code, MID);

        // Async reset while holding a valid result.
        run_cal(20, 1'b0, 1'b0, "pre_rst");
        @(negedge clk); #1; rst = 1'b1; #1;
        check("idle_rst_trim", trim_code, MID);
        check("idle_rst_cal_valid", cal_valid, 0);
        @(negedge clk); rst = 1'b0;

        // Async reset mid-run, checked before any clock edge.
        threshold = 10;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (PER_BIT + 10) @(posedge clk);
        @(negedge clk); #1;
        check("mid_pre_busy", busy, 1);
        rst = 1'b1; #1;
        check("mid_rst_trim", trim_code, MID);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cal_valid", cal_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        busy_seen = 0; done_seen = 0;
        for (int i = 0; i < BUSY_EXP + 8; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        check("post_rst_no_busy", busy_seen, 0);
        check("post_rst_no_done", done_seen, 0);

        // A fresh start works after reset.
        run_cal(10, 1'b0, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
